uart_cmd_link: RTL and testbench

Host-side serial link for the logic-analyzer digital core. It receives two-byte commands over a UART RX line and presents them as `cmd[15:0]` with the `cmd_rdy`/`clr_cmd_rdy` handshake. It serializes each 8-bit `resp` byte onto the TX line when `send_resp` pulses, and reports completion on `resp_sent`. It sits directly upstream of the digital core's command configuration path and directly downstream of its response path.

---
 rtl/uart_cmd_link_if.sv | 21 ++
 rtl/uart_cmd_link.sv | 156 +++++++++++++++
 tb/tb_uart_cmd_link.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_link_if.sv
// Command/response handshake between the UART link and the digital core.
interface uart_cmd_link_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  // Digital core side: consumes commands, issues responses.
  modport master (
    input  cmd, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );

  // UART link side: produces commands, serializes responses.
  modport slave (
    output cmd, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/uart_cmd_link.sv
// Host-side UART link: two-byte command receiver and single-byte response transmitter.
// Frame: 1 start (0), 8 data LSB first, 1 stop (1), no parity.
module uart_cmd_link #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RX,
  output logic          TX,
  uart_cmd_link_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV) + 1;
  // Counters run N-1 down to 0, so a terminal count marks exactly N cycles.
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

  logic             rx_meta, rx_s, rx_prev;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bits;
  logic [7:0]       rx_shft;
  logic             rx_tick_c, byte_done_c, frame_err_c;
  logic             hi_ptr;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bits;
  logic [9:0]       tx_shft;

  assign rx_tick_c   = (rx_cnt == '0);
  assign byte_done_c = (rx_state == RX_STOP) && rx_tick_c && rx_s;
  assign frame_err_c = (rx_state == RX_STOP) && rx_tick_c && !rx_s;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; all idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Receive FSM: mid-bit sampling, first sample half a bit after the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shft  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_cnt   <= HALF_LD;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tick_c) begin
            if (rx_s) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_cnt   <= FULL_LD;
              rx_bits  <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tick_c) begin
            rx_shft <= {rx_s, rx_shft[7:1]};
            rx_cnt  <= FULL_LD;
            rx_bits <= rx_bits + 1'b1;
            if (rx_bits == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          // Leave at the stop sample so a back-to-back start edge is not missed.
          if (rx_tick_c) rx_state <= RX_IDLE;
          else           rx_cnt   <= rx_cnt - 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Byte assembly into cmd; a framing error resynchronizes to the high byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_ptr      <= 1'b1;
      bus.cmd     <= '0;
      bus.cmd_rdy <= 1'b0;
    end else begin
      if (frame_err_c) begin
        hi_ptr <= 1'b1;
      end else if (byte_done_c) begin
        hi_ptr <= !hi_ptr;
        if (hi_ptr) bus.cmd[15:8] <= rx_shft;
        else        bus.cmd[7:0]  <= rx_shft;
      end
      // Completion of a low byte beats a simultaneous clear.
      if (byte_done_c && !hi_ptr)
        bus.cmd_rdy <= 1'b1;
      else if (bus.clr_cmd_rdy || (byte_done_c && hi_ptr))
        bus.cmd_rdy <= 1'b0;
    end
  end

  // Transmit FSM: shifter fills with ones so TX rests high once the frame is out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      tx_bits       <= '0;
      tx_shft       <= '1;
      bus.resp_sent <= 1'b0;
    end else begin
      bus.resp_sent <= 1'b0;
      if (tx_state == TX_IDLE) begin
        if (bus.send_resp) begin
          tx_shft  <= {1'b1, bus.resp, 1'b0};
          tx_cnt   <= FULL_LD;
          tx_bits  <= '0;
          tx_state <= TX_XMIT;
        end
      end else begin
        if (tx_cnt == '0) begin
          tx_shft <= {1'b1, tx_shft[9:1]};
          tx_cnt  <= FULL_LD;
          tx_bits <= tx_bits + 1'b1;
          if (tx_bits == 4'd9) begin
            bus.resp_sent <= 1'b1;
            tx_state      <= TX_IDLE;
          end
        end else begin
          tx_cnt <= tx_cnt - 1'b1;
        end
      end
    end
  end

  assign TX = tx_shft[0];

endmodule

// File: tb/tb_uart_cmd_link.sv
// Self-checking bench for uart_cmd_link with BAUD_DIV = 16.
`timescale 1ns/1ps
module tb_uart_cmd_link;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic RX = 1'b1;
  logic TX;

  uart_cmd_link_if bus();

  uart_cmd_link #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (RX),
    .TX    (TX),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int last_start = 0;
  int rdy_rise = -1;
  int sent_cnt = 0;
  logic rdy_d = 1'b0;

  // Cycle in which cmd_rdy last rose, and a running count of resp_sent pulses.
  always @(negedge clk) begin
    if (bus.cmd_rdy === 1'b1 && rdy_d !== 1'b1) rdy_rise = cyc;
    rdy_d = bus.cmd_rdy;
    if (bus.resp_sent === 1'b1) sent_cnt++;
  end

  // Reference model of the command receiver: list of bytes of the pending command.
  logic [7:0]  mq[$];
  logic [15:0] m_cmd = 16'h0000;
  logic        m_rdy = 1'b0;

  function automatic void model_byte(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) begin
      mq.delete();
      return;
    end
    mq.push_back(b);
    if (mq.size() == 1) begin
      m_cmd = {b, m_cmd[7:0]};
      m_rdy = 1'b0;
    end else begin
      m_cmd = {mq[0], mq[1]};
      m_rdy = 1'b1;
      mq.delete();
    end
  endfunction

  // Expected line levels of one frame, in transmission order.
  function automatic logic [9:0] frame_of(input logic [7:0] r);
    logic [9:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = r[i];
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; clr_cmd_rdy is pulsed in frame cycle clr_at (negative = never).
  task automatic send_byte(input logic [7:0] b, input logic stop, input int clr_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int t = 0; t < 10 * BD; t++) begin
      if (t == 0) last_start = cyc;
      RX = fr[t / BD];
      bus.clr_cmd_rdy = (t == clr_at);
      @(negedge clk);
    end
    bus.clr_cmd_rdy = 1'b0;
    model_byte(b, stop);
  endtask

  task automatic send_cmd(input logic [15:0] c, input int gap);
    send_byte(c[15:8], 1'b1, -1);
    idle(gap);
    send_byte(c[7:0], 1'b1, -1);
  endtask

  task automatic clr_pulse(input string nm);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    chk({nm, " clr rdy"}, 32'(bus.cmd_rdy), 32'(m_rdy));
    chk({nm, " clr cmd held"}, 32'(bus.cmd), 32'(m_cmd));
  endtask

  // Request a transmission and check every cycle of the frame plus the completion pulse.
  task automatic tx_frame(input logic [7:0] r, input logic [9:0] exp_fr, input int dup_at,
                          input string nm);
    int n;
    logic ok;
    bus.resp = r;
    bus.send_resp = 1'b1;
    n = cyc;
    @(negedge clk);
    bus.send_resp = 1'b0;
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int k = 0; k < BD; k++) begin
        if (cyc - n == dup_at) begin
          bus.resp = ~r;
          bus.send_resp = 1'b1;
        end else begin
          bus.send_resp = 1'b0;
        end
        if (TX !== exp_fr[b] || bus.resp_sent !== 1'b0) ok = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d level", nm, b), 32'(ok), 32'd1);
    end
    bus.send_resp = 1'b0;
    chk({nm, " resp_sent at N+161"}, 32'(bus.resp_sent), 32'd1);
    chk({nm, " TX idle at N+161"}, 32'(TX), 32'd1);
    @(negedge clk);
    chk({nm, " resp_sent single"}, 32'(bus.resp_sent), 32'd0);
  endtask

  typedef struct {
    logic [15:0] c;
    int          gap;
    logic [7:0]  r;
    logic [9:0]  fr;
  } vec_t;

  initial begin
    vec_t tbl[4];
    logic [15:0] rc;
    logic [7:0]  rr;
    int          rg;
    int          sent0;

    tbl[0] = '{16'h8A55, 0,  8'hA5, 10'b1101001010};
    tbl[1] = '{16'h0000, 5,  8'h00, 10'b1000000000};
    tbl[2] = '{16'hFFFF, 0,  8'hFF, 10'b1111111110};
    tbl[3] = '{16'h1E3C, 30, 8'h3C, 10'b1001111000};

    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    bus.resp = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset TX", 32'(TX), 32'd1);
    chk("reset cmd", 32'(bus.cmd), 32'd0);
    chk("reset cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("reset resp_sent", 32'(bus.resp_sent), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Table: one command received while one response is transmitted.
    for (int i = 0; i < 4; i++) begin
      fork
        send_cmd(tbl[i].c, tbl[i].gap);
        tx_frame(tbl[i].r, tbl[i].fr, (i == 0) ? 40 : -1, $sformatf("tbl%0d tx", i));
      join
      chk($sformatf("tbl%0d cmd", i), 32'(bus.cmd), 32'(tbl[i].c));
      chk($sformatf("tbl%0d cmd_rdy", i), 32'(bus.cmd_rdy), 32'd1);
      if (i == 0) chk("tbl0 rdy latency", 32'(rdy_rise - last_start), 32'd155);
      clr_pulse($sformatf("tbl%0d", i));
      idle(3);
    end

    // Short low glitch must be rejected as a false start.
    RX = 1'b0;
    repeat (4) @(negedge clk);
    idle(200);
    chk("glitch cmd", 32'(bus.cmd), 32'(m_cmd));
    chk("glitch cmd_rdy", 32'(bus.cmd_rdy), 32'(m_rdy));

    // Framing error on the high byte drops it and resynchronizes.
    send_byte(8'h12, 1'b0, -1);
    idle(20);
    chk("frame err cmd held", 32'(bus.cmd), 32'h1E3C);
    send_byte(8'h34, 1'b1, -1);
    send_byte(8'h56, 1'b1, -1);
    chk("frame err cmd", 32'(bus.cmd), 32'h3456);
    chk("frame err cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    clr_pulse("frame err");
    idle(5);

    // Clear in the same cycle a low byte completes: set wins.
    send_byte(8'hC0, 1'b1, -1);
    send_byte(8'hFF, 1'b1, 154);
    chk("set wins cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("set wins cmd", 32'(bus.cmd), 32'hC0FF);

    // A new high byte clears a pending cmd_rdy.
    send_byte(8'hAB, 1'b1, -1);
    chk("hi byte clears rdy", 32'(bus.cmd_rdy), 32'(m_rdy));
    chk("hi byte cmd", 32'(bus.cmd), 32'(m_cmd));
    send_byte(8'hCD, 1'b1, -1);
    chk("hi/lo cmd", 32'(bus.cmd), 32'hABCD);
    idle(4);

    // Random full-duplex traffic against the model.
    for (int i = 0; i < 8; i++) begin
      rc = 16'($urandom);
      rr = 8'($urandom);
      rg = int'($urandom_range(0, 25));
      fork
        send_cmd(rc, rg);
        tx_frame(rr, frame_of(rr), -1, $sformatf("rnd%0d tx", i));
      join
      chk($sformatf("rnd%0d cmd", i), 32'(bus.cmd), 32'(m_cmd));
      chk($sformatf("rnd%0d cmd_rdy", i), 32'(bus.cmd_rdy), 32'(m_rdy));
      if ($urandom_range(0, 1) == 1) clr_pulse($sformatf("rnd%0d", i));
      idle(int'($urandom_range(0, 6)));
    end

    // Reset in the middle of an RX and a TX frame.
    send_cmd(16'h5AA5, 0);
    idle(2);
    sent0 = sent_cnt;
    bus.resp = 8'h81;
    bus.send_resp = 1'b1;
    RX = 1'b0;
    @(negedge clk);
    bus.send_resp = 1'b0;
    repeat (15) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    chk("pre-reset TX low", 32'(TX), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid reset TX", 32'(TX), 32'd1);
    chk("mid reset cmd", 32'(bus.cmd), 32'd0);
    chk("mid reset cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_cmd = 16'h0000;
    m_rdy = 1'b0;
    idle(200);
    chk("post reset no resp_sent", 32'(sent_cnt - sent0), 32'd0);
    chk("post reset cmd", 32'(bus.cmd), 32'd0);
    send_cmd(16'h0102, 0);
    chk("post reset cmd 0102", 32'(bus.cmd), 32'h0102);
    chk("post reset cmd_rdy", 32'(bus.cmd_rdy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
